// File: rtl/decode_pipe_stage_if.sv
// Fetch-to-decode handshake plus the registered ID/EX payload toward execute.
// The decode stage uses the slave view and the surrounding pipeline uses the master view.
interface decode_pipe_stage_if #(
    parameter int unsigned DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic [3:0]    status_reg;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    ex_cmd;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          wb_en_out;
    logic          s_out;
    logic          b_out;
    logic          imm_out;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic [11:0]   shift_op;
    logic [23:0]   simm24;
    logic [3:0]    dest;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic          two_src;

    modport master (
        output in_valid, instruction, status_reg, out_ready,
        input  in_ready, out_valid, ex_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out,
               imm_out, val_rn, val_rm, shift_op, simm24, dest, src1, src2, two_src
    );

    modport slave (
        input  in_valid, instruction, status_reg, out_ready,
        output in_ready, out_valid, ex_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out,
               imm_out, val_rn, val_rm, shift_op, simm24, dest, src1, src2, two_src
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// ARM-style instruction decode stage: field decode, condition check, register file
// with optional write-to-read forwarding, and a stallable/flushable ID/EX register.
module decode_pipe_stage #(
    parameter int unsigned DW     = 32,
    parameter int unsigned NREG   = 16,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DW-1:0]     wb_data,
    decode_pipe_stage_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef struct packed {
        logic          valid;
        logic [3:0]    ex_cmd;
        logic          mem_r_en;
        logic          mem_w_en;
        logic          wb_en_out;
        logic          s_out;
        logic          b_out;
        logic          imm_out;
        logic [DW-1:0] val_rn;
        logic [DW-1:0] val_rm;
        logic [11:0]   shift_op;
        logic [23:0]   simm24;
        logic [3:0]    dest;
        logic [3:0]    src1;
        logic [3:0]    src2;
        logic          two_src;
    } idex_t;

    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] val_rn_c, val_rm_c;
    logic [AW-1:0] ra_c, rb_c;
    idex_t         dec_c, idex_n, idex_q;
    logic          advance_c, live_c, is_str_c;

    logic [3:0] cond_f, opcode_f, rn_f, rd_f, rm_f;
    logic [1:0] mode_f;
    logic       imm_f, s_f;

    assign cond_f   = bus.instruction[31:28];
    assign mode_f   = bus.instruction[27:26];
    assign imm_f    = bus.instruction[25];
    assign opcode_f = bus.instruction[24:21];
    assign s_f      = bus.instruction[20];
    assign rn_f     = bus.instruction[19:16];
    assign rd_f     = bus.instruction[15:12];
    assign rm_f     = bus.instruction[3:0];
    assign is_str_c = (mode_f == 2'b01) && !s_f;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Register file: synchronous clear and write, asynchronous reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_dest[AW-1:0]] <= wb_data;
        end
    end

    always_comb begin
        ra_c     = rn_f[AW-1:0];
        rb_c     = is_str_c ? rd_f[AW-1:0] : rm_f[AW-1:0];
        val_rn_c = rf[ra_c];
        val_rm_c = rf[rb_c];
        if (BYPASS != 0 && wb_en && wb_dest[AW-1:0] == ra_c) val_rn_c = wb_data;
        if (BYPASS != 0 && wb_en && wb_dest[AW-1:0] == rb_c) val_rm_c = wb_data;
    end

    always_comb begin
        dec_c          = '0;
        dec_c.imm_out  = imm_f;
        dec_c.val_rn   = val_rn_c;
        dec_c.val_rm   = val_rm_c;
        dec_c.shift_op = bus.instruction[11:0];
        dec_c.simm24   = bus.instruction[23:0];
        dec_c.dest     = rd_f;
        dec_c.src1     = rn_f;
        dec_c.src2     = is_str_c ? rd_f : rm_f;
        dec_c.two_src  = !imm_f || is_str_c;
        case (mode_f)
            2'b00: begin
                dec_c.wb_en_out = 1'b1;
                dec_c.s_out     = s_f;
                case (opcode_f)
                    4'b1101: dec_c.ex_cmd = 4'b0001;
                    4'b1111: dec_c.ex_cmd = 4'b1001;
                    4'b0100: dec_c.ex_cmd = 4'b0010;
                    4'b0101: dec_c.ex_cmd = 4'b0011;
                    4'b0010: dec_c.ex_cmd = 4'b0100;
                    4'b0110: dec_c.ex_cmd = 4'b0101;
                    4'b0000: dec_c.ex_cmd = 4'b0110;
                    4'b1100: dec_c.ex_cmd = 4'b0111;
                    4'b0001: dec_c.ex_cmd = 4'b1000;
                    4'b1010: begin
                        dec_c.ex_cmd    = 4'b0100;
                        dec_c.wb_en_out = 1'b0;
                        dec_c.s_out     = 1'b1;
                    end
                    4'b1000: begin
                        dec_c.ex_cmd    = 4'b0110;
                        dec_c.wb_en_out = 1'b0;
                        dec_c.s_out     = 1'b1;
                    end
                    default: begin
                        dec_c.wb_en_out = 1'b0;
                        dec_c.s_out     = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_c.ex_cmd    = 4'b0010;
                dec_c.mem_r_en  = s_f;
                dec_c.wb_en_out = s_f;
                dec_c.mem_w_en  = !s_f;
            end
            2'b10:   dec_c.b_out = 1'b1;
            default: ;
        endcase
        // A failed condition still occupies the slot but has no side effects
        if (!cond_pass(cond_f, bus.status_reg)) begin
            dec_c.ex_cmd    = '0;
            dec_c.mem_r_en  = 1'b0;
            dec_c.mem_w_en  = 1'b0;
            dec_c.wb_en_out = 1'b0;
            dec_c.s_out     = 1'b0;
            dec_c.b_out     = 1'b0;
        end
    end

    assign advance_c = bus.out_ready || !idex_q.valid;
    assign live_c    = bus.in_valid && !hazard && !flush;

    // Next ID/EX contents; bubbles never carry live enables
    always_comb begin
        idex_n = idex_q;
        if (advance_c) begin
            idex_n       = dec_c;
            idex_n.valid = live_c;
        end else if (flush) begin
            idex_n.valid = 1'b0;
        end
        if (!idex_n.valid) begin
            idex_n.ex_cmd    = '0;
            idex_n.mem_r_en  = 1'b0;
            idex_n.mem_w_en  = 1'b0;
            idex_n.wb_en_out = 1'b0;
            idex_n.s_out     = 1'b0;
            idex_n.b_out     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_n;
    end

    assign bus.in_ready  = rst && !hazard && advance_c;
    assign bus.out_valid = idex_q.valid;
    assign bus.ex_cmd    = idex_q.ex_cmd;
    assign bus.mem_r_en  = idex_q.mem_r_en;
    assign bus.mem_w_en  = idex_q.mem_w_en;
    assign bus.wb_en_out = idex_q.wb_en_out;
    assign bus.s_out     = idex_q.s_out;
    assign bus.b_out     = idex_q.b_out;
    assign bus.imm_out   = idex_q.imm_out;
    assign bus.val_rn    = idex_q.val_rn;
    assign bus.val_rm    = idex_q.val_rm;
    assign bus.shift_op  = idex_q.shift_op;
    assign bus.simm24    = idex_q.simm24;
    assign bus.dest      = idex_q.dest;
    assign bus.src1      = idex_q.src1;
    assign bus.src2      = idex_q.src2;
    assign bus.two_src   = idex_q.two_src;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: a decode vector table plus hand-written
// sequences for reset, forwarding, hazard, stall and flush behaviour.
module tb_decode_pipe_stage;
    logic        clk;
    logic        rst;
    logic        hazard, flush, wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    int          total = 0;
    int          bad   = 0;

    decode_pipe_stage_if #(.DW(32)) bus1 ();
    decode_pipe_stage_if #(.DW(32)) bus0 ();

    decode_pipe_stage #(.DW(32), .NREG(16), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .bus(bus1)
    );

    decode_pipe_stage #(.DW(32), .NREG(16), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .hazard(hazard), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .bus(bus0)
    );

    assign bus0.in_valid    = bus1.in_valid;
    assign bus0.instruction = bus1.instruction;
    assign bus0.status_reg  = bus1.status_reg;
    assign bus0.out_ready   = bus1.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [8:0]  ctl;  // {ex_cmd, mem_r_en, mem_w_en, wb_en_out, s_out, b_out}
        logic [13:0] fld;  // {imm_out, dest, src1, src2, two_src}
    } vec_t;

    vec_t vt[$];

    localparam logic [8:0] CTL_ADD = 9'b0010_00100;
    localparam logic [8:0] CTL_STR = 9'b0010_01000;

    function automatic logic [31:0] enc(input logic [3:0] c, input logic [1:0] m, input logic i,
                                        input logic [3:0] op, input logic s, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] op2);
        return {c, m, i, op, s, rn, rd, op2};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic [3:0] f, input logic [3:0] ex,
                                input logic mr, input logic mw, input logic wb, input logic s,
                                input logic b, input logic imm, input logic [3:0] d,
                                input logic [3:0] s1, input logic [3:0] s2, input logic two);
        vec_t v;
        v.instr = ins;
        v.flags = f;
        v.ctl   = {ex, mr, mw, wb, s, b};
        v.fld   = {imm, d, s1, s2, two};
        return v;
    endfunction

    function automatic logic [8:0] ctl1();
        return {bus1.ex_cmd, bus1.mem_r_en, bus1.mem_w_en, bus1.wb_en_out, bus1.s_out, bus1.b_out};
    endfunction

    function automatic logic [13:0] fld1();
        return {bus1.imm_out, bus1.dest, bus1.src1, bus1.src2, bus1.two_src};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_dest = r;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; hazard = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_dest = '0; wb_data = '0;
        bus1.in_valid = 1'b0; bus1.instruction = '0; bus1.status_reg = '0; bus1.out_ready = 1'b1;

        vt.push_back(mk(32'hE2821005, 4'b0000, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(32'hE5843000, 4'b0000, 4'h2, 0,1,0,0,0, 0, 4'd3, 4'd4, 4'd3, 1));
        vt.push_back(mk(enc(4'hE,2'b01,1'b0,4'hC,1'b1,4'd6,4'd5,12'h000), 4'b0000, 4'h2, 1,0,1,0,0, 0, 4'd5, 4'd6, 4'd0, 1));
        vt.push_back(mk(32'h03A01007, 4'b0000, 4'h0, 0,0,0,0,0, 1, 4'd1, 4'd0, 4'd7, 0));
        vt.push_back(mk(32'h03A01007, 4'b0100, 4'h1, 0,0,1,0,0, 1, 4'd1, 4'd0, 4'd7, 0));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'h2,1'b1,4'd1,4'd3,12'h002), 4'b0000, 4'h4, 0,0,1,1,0, 0, 4'd3, 4'd1, 4'd2, 1));
        vt.push_back(mk(enc(4'hE,2'b00,1'b1,4'hA,1'b0,4'd4,4'd0,12'h001), 4'b0000, 4'h4, 0,0,0,1,0, 1, 4'd0, 4'd4, 4'd1, 0));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'h8,1'b0,4'd7,4'd0,12'h008), 4'b0000, 4'h6, 0,0,0,1,0, 0, 4'd0, 4'd7, 4'd8, 1));
        vt.push_back(mk(enc(4'hE,2'b00,1'b1,4'hF,1'b0,4'd0,4'd9,12'h0FF), 4'b0000, 4'h9, 0,0,1,0,0, 1, 4'd9, 4'd0, 4'hF, 0));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'hC,1'b1,4'd1,4'd2,12'h003), 4'b0000, 4'h7, 0,0,1,1,0, 0, 4'd2, 4'd1, 4'd3, 1));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'h1,1'b0,4'd3,4'd4,12'h005), 4'b0000, 4'h8, 0,0,1,0,0, 0, 4'd4, 4'd3, 4'd5, 1));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'h0,1'b0,4'd1,4'd1,12'h001), 4'b0000, 4'h6, 0,0,1,0,0, 0, 4'd1, 4'd1, 4'd1, 1));
        vt.push_back(mk(enc(4'hE,2'b00,1'b1,4'h5,1'b0,4'd2,4'd2,12'h000), 4'b0000, 4'h3, 0,0,1,0,0, 1, 4'd2, 4'd2, 4'd0, 0));
        vt.push_back(mk(enc(4'hE,2'b00,1'b1,4'h6,1'b1,4'd2,4'd2,12'h000), 4'b0000, 4'h5, 0,0,1,1,0, 1, 4'd2, 4'd2, 4'd0, 0));
        vt.push_back(mk(enc(4'hE,2'b00,1'b0,4'h3,1'b1,4'd1,4'd2,12'h003), 4'b0000, 4'h0, 0,0,0,0,0, 0, 4'd2, 4'd1, 4'd3, 1));
        vt.push_back(mk(32'hEA000010, 4'b0000, 4'h0, 0,0,0,0,1, 1, 4'd0, 4'd0, 4'd0, 0));
        vt.push_back(mk(32'h1A000004, 4'b0000, 4'h0, 0,0,0,0,1, 1, 4'd0, 4'd0, 4'd4, 0));
        vt.push_back(mk(32'h1A000004, 4'b0100, 4'h0, 0,0,0,0,0, 1, 4'd0, 4'd0, 4'd4, 0));
        vt.push_back(mk(32'hF2821005, 4'b0000, 4'h0, 0,0,0,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(32'hEC000000, 4'b0000, 4'h0, 0,0,0,0,0, 0, 4'd0, 4'd0, 4'd0, 1));
        vt.push_back(mk(enc(4'hA,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b1001, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'hB,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b1000, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'hC,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0000, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'h8,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0110, 4'h0, 0,0,0,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'h9,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0010, 4'h0, 0,0,0,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'hD,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0100, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'h2,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0010, 4'h2, 0,0,1,0,0, 1, 4'd1, 4'd2, 4'd5, 0));
        vt.push_back(mk(enc(4'h6,2'b00,1'b1,4'h4,1'b0,4'd2,4'd1,12'h005), 4'b0000, 4'h0, 0,0,0,0,0, 1, 4'd1, 4'd2, 4'd5, 0));

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
        chk("rst_ctl", 64'(ctl1()), 64'd0);
        chk("rst_fld", 64'(fld1()), 64'd0);
        chk("rst_val_rn", 64'(bus1.val_rn), 64'd0);
        chk("rst_in_ready", 64'(bus1.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", 64'(bus1.in_ready), 64'd1);

        wr(4'd3, 32'hCAFE0003);
        wr(4'd4, 32'h00000044);
        wr(4'd2, 32'h00001111);

        // STR reads Rd through the second port
        bus1.in_valid = 1'b1;
        bus1.instruction = 32'hE5843000;
        tick();
        chk("str_valid", 64'(bus1.out_valid), 64'd1);
        chk("str_val_rm", 64'(bus1.val_rm), 64'hCAFE0003);
        chk("str_val_rn", 64'(bus1.val_rn), 64'h44);

        // Same-cycle write-back of R2 while decoding a read of R2
        bus1.instruction = 32'hE2821005;
        wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'h00001234;
        tick();
        wb_en = 1'b0;
        chk("bypass_on_val_rn", 64'(bus1.val_rn), 64'h1234);
        chk("bypass_off_val_rn", 64'(bus0.val_rn), 64'h1111);
        tick();
        chk("bypass_off_after", 64'(bus0.val_rn), 64'h1234);

        // Back-to-back decode table
        for (int i = 0; i < vt.size(); i++) begin
            bus1.instruction = vt[i].instr;
            bus1.status_reg  = vt[i].flags;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus1.out_valid), 64'd1);
            chk($sformatf("vec%0d_ctl", i), 64'(ctl1()), 64'(vt[i].ctl));
            chk($sformatf("vec%0d_fld", i), 64'(fld1()), 64'(vt[i].fld));
        end
        bus1.status_reg = 4'b0000;

        // Two-cycle hazard
        bus1.instruction = enc(4'hE, 2'b00, 1'b1, 4'h4, 1'b0, 4'd2, 4'd7, 12'h005);
        hazard = 1'b1;
        #1;
        chk("haz_in_ready", 64'(bus1.in_ready), 64'd0);
        tick();
        chk("haz_bubble1", 64'(bus1.out_valid), 64'd0);
        tick();
        chk("haz_bubble2", 64'(bus1.out_valid), 64'd0);
        chk("haz_in_ready2", 64'(bus1.in_ready), 64'd0);
        hazard = 1'b0;
        tick();
        chk("haz_issue_valid", 64'(bus1.out_valid), 64'd1);
        chk("haz_issue_dest", 64'(bus1.dest), 64'd7);

        // Downstream stall holds outputs
        bus1.out_ready = 1'b0;
        bus1.instruction = 32'hE5843000;
        #1;
        chk("stall_in_ready", 64'(bus1.in_ready), 64'd0);
        tick();
        tick();
        chk("stall_valid", 64'(bus1.out_valid), 64'd1);
        chk("stall_dest", 64'(bus1.dest), 64'd7);
        chk("stall_ctl", 64'(ctl1()), 64'(CTL_ADD));
        bus1.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 64'(bus1.in_ready), 64'd1);
        tick();
        chk("unstall_dest", 64'(bus1.dest), 64'd3);
        chk("unstall_ctl", 64'(ctl1()), 64'(CTL_STR));

        // Flush with a valid input
        bus1.instruction = 32'hE2821005;
        flush = 1'b1;
        tick();
        chk("flush_valid", 64'(bus1.out_valid), 64'd0);
        chk("flush_ctl", 64'(ctl1()), 64'd0);
        flush = 1'b0;
        tick();
        chk("post_flush_valid", 64'(bus1.out_valid), 64'd1);

        // Flush while stalled
        bus1.out_ready = 1'b0;
        flush = 1'b1;
        tick();
        chk("flush_stall_valid", 64'(bus1.out_valid), 64'd0);
        flush = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset in the middle of a stall
        tick();
        chk("pre_rst_valid", 64'(bus1.out_valid), 64'd1);
        bus1.out_ready = 1'b0;
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(bus1.out_valid), 64'd0);
        chk("mid_rst_ctl", 64'(ctl1()), 64'd0);
        chk("mid_rst_fld", 64'(fld1()), 64'd0);
        chk("mid_rst_in_ready", 64'(bus1.in_ready), 64'd0);
        rst = 1'b1;
        bus1.out_ready = 1'b1;
        bus1.instruction = 32'hE5843000;
        tick();
        chk("after_rst_valid", 64'(bus1.out_valid), 64'd1);
        chk("after_rst_ctl", 64'(ctl1()), 64'(CTL_STR));
        chk("after_rst_val_rm", 64'(bus1.val_rm), 64'd0);
        chk("after_rst_val_rn", 64'(bus1.val_rn), 64'd0);
        bus1.in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(bus1.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
